// File: rtl/calc_pkg.sv
// calc_pkg: shared opcode/state enums and the seven-segment table for the calculator ALU
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active-high; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex digit to seven-segment lookup
module hex_to_seg7
    import calc_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG7_TABLE[hex];

endmodule

// File: rtl/calc_alu_seq.sv
// calc_alu_seq: sequential add/sub/mul/div ALU with valid/ready handshake; SEG7_OUT_EN enables the seg decode
module calc_alu_seq
    import calc_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           ctrl,
    input  logic [WIDTH-1:0]     i1,
    input  logic [WIDTH-1:0]     i2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err,
    output logic [6:0]           seg
);

    state_t               state, state_nxt;
    op_t                  op;
    logic [CNT_W-1:0]     count;
    logic [2*WIDTH-1:0]   acc, acc_nxt, res_nxt;
    logic [WIDTH-1:0]     b;
    logic [WIDTH:0]       sum, rsh, diff, add_r, sub_r;
    logic                 accept, last, load, err_nxt;
    logic [6:0]           seg_nxt;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    // One shift-add or restoring-divide step on acc; both share b as the second operand.
    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
        rsh       = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff      = rsh - {1'b0, b};
        acc_nxt   = op == OP_MUL ? {sum, acc[WIDTH-1:1]}
                  : diff[WIDTH]  ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                  :                {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        add_r     = {1'b0, i1} + {1'b0, i2};
        sub_r     = {1'b0, i1} - {1'b0, i2};
        accept    = in_valid && state == IDLE;
        last      = state == BUSY && count == CNT_W'(WIDTH - 1);
        load      = (accept && !ctrl[1]) || last;
        res_nxt   = last ? acc_nxt : {{(WIDTH-1){1'b0}}, ctrl[0] ? sub_r : add_r};
        err_nxt   = last && op == OP_DIV && b == '0;
        state_nxt = accept ? (ctrl[1] ? BUSY : DONE)
                  : last ? DONE
                  : (state == DONE && out_ready) ? IDLE
                  : state;
    end

`ifdef SEG7_OUT_EN
    hex_to_seg7 u_seg (
        .hex (res_nxt[3:0]),
        .seg (seg_nxt)
    );
`else
    assign seg_nxt = 7'b0000000;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, iteration, and result/err/seg registers held until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op     <= OP_ADD;
            b      <= '0;
            acc    <= '0;
            count  <= '0;
            result <= '0;
            err    <= 1'b0;
            seg    <= 7'b0000000;
        end else begin
            if (accept) begin
                op    <= op_t'(ctrl);
                b     <= i2;
                acc   <= {{WIDTH{1'b0}}, i1};
                count <= '0;
            end else if (state == BUSY) begin
                acc   <= acc_nxt;
                count <= count + CNT_W'(1);
            end
            if (load) begin
                result <= res_nxt;
                err    <= err_nxt;
                seg    <= seg_nxt;
            end
        end
    end

endmodule
